rand_step_ctrl: RTL and testbench
=================================

// Module: rand_step_ctrl
// PURPOSE
//  Sequencer for the 8-bit LFSR random-number datapath that feeds the seg_hex display.
//  Replaces direct button clocking of the LFSR with a single-clock design:
//  - raw buttons are synchronised and debounced;
//  - the LFSR is stepped under manual or auto-run control and can be seed-loaded.
//  The LFSR register is owned here. rand_num drives seg_hex.bit_sel.
// PARAMETERS
//  DEBOUNCE_CYCLES  16    consecutive stable cycles before a debounced level changes (>=2)
//  AUTO_PERIOD      1000  clk cycles between advances in AUTO mode (>=2)
//  SEED             8'h01 reset value; also substituted when a zero seed is loaded (nonzero)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   asynchronous, active-low reset
//  btn_step    in   1   raw step button, async, bouncy, active-high
//  btn_mode    in   1   raw MANUAL/AUTO toggle button, async, active-high
//  btn_load    in   1   raw seed-load button, async, active-high
//  sw_seed     in   8   seed switches, sampled through the same 2-FF sync, quasi-static
//  rand_num    out  8   current LFSR value
//  step_pulse  out  1   high for 1 cycle, coincident with each advance or load of rand_num
//  auto_mode   out  1   1 = AUTO, 0 = MANUAL
//  step_count  out  16  advances since last load/reset; wraps 0xFFFF->0x0000
// BEHAVIOUR
//  Reset (rst=0, async):
//  - rand_num=SEED, step_pulse=0, auto_mode=0, step_count=0.
//  - Period counter=0, debounced levels=0, sync FFs=0.
//  Input path, per button:
//  - 2-FF synchroniser, then debounce counter.
//  - Debounced level takes the synced value only after DEBOUNCE_CYCLES consecutive equal cycles.
//  - Any mismatch clears the counter.
//  - Rising edge of the debounced level gives a 1-cycle event (ev_step/ev_mode/ev_load).
//  - Latency: a clean raw rise gives rand_num update exactly DEBOUNCE_CYCLES+3 cycles later.
//  LFSR advance: next = {r[4]^r[3]^r[2]^r[0], r[7:1]}.
//  Load: rand_num <= (sw_seed==0) ? SEED : sw_seed. The all-zero state is never reachable.
//  FSM states:
//  - MANUAL: ev_step advances once. ev_mode goes to AUTO and clears the period counter.
//  - AUTO: period counter runs 0..AUTO_PERIOD-1. At AUTO_PERIOD-1 it advances and wraps to 0.
//    ev_step is ignored. ev_mode goes to MANUAL; no advance that cycle even if the counter is at terminal.
//  - Load (either state): load rand_num, step_count<=0, period counter<=0, state unchanged, step_pulse=1.
//  Simultaneous events, priority load > mode > step/auto-advance:
//  - At most one rand_num change per cycle.
//  - A lower-priority event in the same cycle is dropped, not deferred.
//  step_count: +1 per advance, not per load. Wraps silently.
//  All outputs are registered. No combinational input-to-output path.
//  Reset mid-bounce or mid-period discards all partial counts. Held buttons produce one event only.
// TESTING
//  1. Reset, DEBOUNCE_CYCLES=4 -> rand_num=0x01, auto_mode=0, step_count=0, step_pulse=0.
//  2. Five clean btn_step presses -> rand_num 0x80,0x40,0x20,0x10,0x88; step_count=5.
//     Each update arrives exactly 7 cycles after the raw rise.
//  3. btn_step glitches high for 3 cycles then low (DEBOUNCE_CYCLES=4) -> no step_pulse, rand_num unchanged.
//  4. sw_seed=0xA5, press btn_load -> rand_num=0xA5, step_count=0.
//     Then one step -> 0x52. sw_seed=0x00 + load -> rand_num=0x01.
//  5. AUTO_PERIOD=4, press btn_mode -> auto_mode=1, step_pulse every 4th cycle.
//     btn_step presses are ignored. Press btn_mode -> pulses stop.
//  6. Reset asserted mid-AUTO and mid-debounce -> immediate return to the test-1 values.
//     No event fires after release while buttons are low.

Source files
------------

// File: rtl/rand_step_ctrl.sv
// Single-clock sequencer for the 8-bit LFSR random-number datapath feeding seg_hex.
// Buttons are synchronised and debounced; the LFSR steps manually, auto-runs, or seed-loads.
module rand_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned AUTO_PERIOD     = 1000,
  parameter logic [7:0]  SEED            = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        btn_mode,
  input  logic        btn_load,
  input  logic [7:0]  sw_seed,
  output logic [7:0]  rand_num,
  output logic        step_pulse,
  output logic        auto_mode,
  output logic [15:0] step_count
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PW = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DW-1:0] DBC_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(AUTO_PERIOD - 1);

  localparam logic ST_MANUAL = 1'b0;
  localparam logic ST_AUTO   = 1'b1;

  // Button index: 0 = step, 1 = mode, 2 = load
  logic [2:0]    w_btn_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_deb;
  logic [2:0]    r_deb_d;
  logic [DW-1:0] r_dcnt [3];
  logic [7:0]    r_seed_s1;
  logic [7:0]    r_seed_s2;

  logic          r_state;
  logic [7:0]    r_rand;
  logic          r_pulse;
  logic [15:0]   r_cnt;
  logic [PW-1:0] r_period;

  logic [2:0]    w_ev;
  logic          w_ev_step;
  logic          w_ev_mode;
  logic          w_ev_load;
  logic [7:0]    w_lfsr_next;
  logic [7:0]    w_seed_eff;

  assign w_btn_raw = {btn_load, btn_mode, btn_step};

  // Debounced level follows the synced input only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_deb     <= '0;
      r_deb_d   <= '0;
      r_seed_s1 <= '0;
      r_seed_s2 <= '0;
      for (int unsigned i = 0; i < 3; i++) r_dcnt[i] <= '0;
    end else begin
      r_sync1   <= w_btn_raw;
      r_sync2   <= r_sync1;
      r_deb_d   <= r_deb;
      r_seed_s1 <= sw_seed;
      r_seed_s2 <= r_seed_s1;
      for (int unsigned i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DBC_LAST) begin
          r_deb[i]  <= r_sync2[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_ev        = r_deb & ~r_deb_d;
  assign w_ev_step   = w_ev[0];
  assign w_ev_mode   = w_ev[1];
  assign w_ev_load   = w_ev[2];
  assign w_lfsr_next = {r_rand[4] ^ r_rand[3] ^ r_rand[2] ^ r_rand[0], r_rand[7:1]};
  assign w_seed_eff  = (r_seed_s2 == '0) ? SEED : r_seed_s2;

  // Priority chain load > mode > advance guarantees at most one rand_num change per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_MANUAL;
      r_rand   <= SEED;
      r_pulse  <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (w_ev_load) begin
        r_rand   <= w_seed_eff;
        r_cnt    <= '0;
        r_period <= '0;
        r_pulse  <= 1'b1;
      end else if (w_ev_mode) begin
        r_state  <= (r_state == ST_MANUAL) ? ST_AUTO : ST_MANUAL;
        r_period <= '0;
      end else if (r_state == ST_AUTO) begin
        if (r_period == PER_LAST) begin
          r_rand   <= w_lfsr_next;
          r_cnt    <= r_cnt + 16'd1;
          r_pulse  <= 1'b1;
          r_period <= '0;
        end else begin
          r_period <= r_period + 1'b1;
        end
      end else if (w_ev_step) begin
        r_rand  <= w_lfsr_next;
        r_cnt   <= r_cnt + 16'd1;
        r_pulse <= 1'b1;
      end
    end
  end

  assign rand_num   = r_rand;
  assign step_pulse = r_pulse;
  assign auto_mode  = (r_state == ST_AUTO);
  assign step_count = r_cnt;

endmodule

// File: tb/tb_rand_step_ctrl.sv
// Directed bench for rand_step_ctrl: table of button presses plus hand sequences
// for glitch rejection, AUTO timing and asynchronous reset.
module tb_rand_step_ctrl;

  localparam int D = 4;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_load = 1'b0;
  logic [7:0]  sw_seed = 8'h00;
  logic [7:0]  rand_num;
  logic        step_pulse;
  logic        auto_mode;
  logic [15:0] step_count;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  rand_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .AUTO_PERIOD    (P),
    .SEED           (8'h01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_step  (btn_step),
    .btn_mode  (btn_mode),
    .btn_load  (btn_load),
    .sw_seed   (sw_seed),
    .rand_num  (rand_num),
    .step_pulse(step_pulse),
    .auto_mode (auto_mode),
    .step_count(step_count)
  );

  typedef struct {
    int unsigned btn;       // 0 step, 2 load
    logic [7:0]  seed;
    logic [7:0]  exp_rand;
    logic [15:0] exp_cnt;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_btn(input int unsigned b, input logic v);
    case (b)
      0:       btn_step = v;
      1:       btn_mode = v;
      default: btn_load = v;
    endcase
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] r);
    return {r[4] ^ r[3] ^ r[2] ^ r[0], r[7:1]};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rand"},  rand_num,   8'h01);
    check({tag, "_auto"},  auto_mode,  1'b0);
    check({tag, "_count"}, step_count, 16'h0000);
    check({tag, "_pulse"}, step_pulse, 1'b0);
  endtask

  // Clean press: update must land exactly D+3 edges after the raw rise, once only.
  task automatic press(input vec_t v);
    bit early;
    bit extra;
    early = 1'b0;
    extra = 1'b0;
    sw_seed = v.seed;
    repeat (3) @(posedge clk);
    #1;
    set_btn(v.btn, 1'b1);
    for (int k = 1; k <= D + 3; k++) begin
      @(posedge clk);
      #1;
      if (k < D + 3 && step_pulse) early = 1'b1;
    end
    check({v.name, "_pulse"}, step_pulse, 1'b1);
    check({v.name, "_rand"},  rand_num,   v.exp_rand);
    check({v.name, "_count"}, step_count, v.exp_cnt);
    check({v.name, "_auto"},  auto_mode,  1'b0);
    check({v.name, "_early"}, early,      1'b0);
    repeat (6) begin
      @(posedge clk);
      #1;
      if (step_pulse) extra = 1'b1;
    end
    set_btn(v.btn, 1'b0);
    repeat (D + 4) begin
      @(posedge clk);
      #1;
      if (step_pulse) extra = 1'b1;
    end
    check({v.name, "_held_once"}, extra, 1'b0);
  endtask

  initial begin
    logic [7:0]  exp_r;
    logic [15:0] exp_c;
    logic        exp_auto;
    logic        exp_pulse;
    bit          seen;
    bit          seen_auto;

    vecs[0] = '{0, 8'h00, 8'h80, 16'd1, "step1"};
    vecs[1] = '{0, 8'h00, 8'h40, 16'd2, "step2"};
    vecs[2] = '{0, 8'h00, 8'h20, 16'd3, "step3"};
    vecs[3] = '{0, 8'h00, 8'h10, 16'd4, "step4"};
    vecs[4] = '{0, 8'h00, 8'h88, 16'd5, "step5"};
    vecs[5] = '{2, 8'hA5, 8'hA5, 16'd0, "load_a5"};
    vecs[6] = '{0, 8'hA5, 8'h52, 16'd1, "step_a5"};
    vecs[7] = '{2, 8'h00, 8'h01, 16'd0, "load_zero"};

    // Reset values while held and just after release
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_rel");

    for (int unsigned i = 0; i < 8; i++) press(vecs[i]);

    // Glitch of D-1 cycles must not produce an event
    seen = 1'b0;
    @(posedge clk);
    #1;
    btn_step = 1'b1;
    repeat (D - 1) @(posedge clk);
    #1;
    btn_step = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (step_pulse) seen = 1'b1;
    end
    check("glitch_pulse", seen, 1'b0);
    check("glitch_rand", rand_num, 8'h01);

    // Enter AUTO
    exp_r = 8'h01;
    exp_c = 16'd0;
    seen_auto = 1'b0;
    @(posedge clk);
    #1;
    btn_mode = 1'b1;
    for (int k = 1; k <= D + 3; k++) begin
      @(posedge clk);
      #1;
      if (k < D + 3 && auto_mode) seen_auto = 1'b1;
    end
    check("mode_early", seen_auto, 1'b0);
    check("mode_auto", auto_mode, 1'b1);
    check("mode_pulse", step_pulse, 1'b0);

    // AUTO run: step press ignored; exit event lands on a terminal count (n=36)
    for (int n = 1; n <= 55; n++) begin
      @(posedge clk);
      #1;
      exp_auto  = (n < 36);
      exp_pulse = exp_auto && (n % P == 0);
      if (exp_pulse) begin
        exp_r = lfsr_next(exp_r);
        exp_c = exp_c + 16'd1;
      end
      check($sformatf("auto_n%0d_mode", n),  auto_mode,  exp_auto);
      check($sformatf("auto_n%0d_pulse", n), step_pulse, exp_pulse);
      check($sformatf("auto_n%0d_rand", n),  rand_num,   exp_r);
      check($sformatf("auto_n%0d_count", n), step_count, exp_c);
      if (n == 2)  begin btn_mode = 1'b0; btn_step = 1'b1; end
      if (n == 14) btn_step = 1'b0;
      if (n == 29) btn_mode = 1'b1;
      if (n == 40) btn_mode = 1'b0;
    end

    // Reset mid-AUTO and mid-debounce
    @(posedge clk);
    #1;
    btn_mode = 1'b1;
    repeat (D + 3) @(posedge clk);
    #1;
    btn_mode = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_auto", auto_mode, 1'b1);
    check("pre_reset_count", step_count, exp_c + 16'd1);
    btn_step = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    btn_step = 1'b0;
    #1;
    check_reset_vals("rst_async");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 1'b0;
    seen_auto = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (step_pulse) seen = 1'b1;
      if (auto_mode) seen_auto = 1'b1;
    end
    check("post_rst_pulse", seen, 1'b0);
    check("post_rst_auto", seen_auto, 1'b0);
    check_reset_vals("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
